// File: rtl/rate_enable_gen_pkg.sv
// Shared types, speed codes and reload computation for rate_enable_gen.
// Optional PulseCount output is selected by the PULSE_COUNT_EN macro.
package rate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] SPD_FULL = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;

  // Computed wide; callers cast to their counter width.
  function automatic logic [63:0] reload_val(input logic [1:0] spd,
                                             input logic [63:0] clk_freq);
    logic [63:0] v;
    case (spd)
      SPD_FULL: v = 64'd0;
      SPD_1HZ:  v = clk_freq - 64'd1;
      SPD_HALF: v = (clk_freq << 1) - 64'd1;
      default:  v = (clk_freq << 2) - 64'd1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rate_enable_gen_if.sv
// Control/status bundle between the rate generator and its user.
// PulseCount exists only when PULSE_COUNT_EN is defined.
// Handshake: none; Speed/Run/Step are levels sampled every rising edge, Enable is a one-cycle registered pulse.
interface rate_enable_gen_if;
  import rate_pkg::*;

  logic [1:0]  Speed;
  logic        Run;
  logic        Step;
  logic        Enable;
  logic        Busy;
`ifdef PULSE_COUNT_EN
  logic [15:0] PulseCount;
`endif

  modport master (
    output Speed, Run, Step,
`ifdef PULSE_COUNT_EN
    input  PulseCount,
`endif
    input  Enable, Busy
  );

  modport slave (
    input  Speed, Run, Step,
`ifdef PULSE_COUNT_EN
    output PulseCount,
`endif
    output Enable, Busy
  );

endinterface

// File: rtl/rate_enable_gen_step_edge_detect.sv
// Registers Step and flags its rising edge; StepQ advances every cycle so a held Step yields one edge.
// Unaffected by PULSE_COUNT_EN.
module step_edge_detect (
  input  logic Clock,
  input  logic Clear,
  input  logic i_step,
  output logic o_rise
);

  logic r_step_q;

  always_ff @(posedge Clock) begin
    if (Clear) r_step_q <= 1'b0;
    else       r_step_q <= i_step;
  end

  assign o_rise = i_step & ~r_step_q;

endmodule

// File: rtl/rate_enable_gen.sv
// Enable pulse generator: IDLE/RUN/STEP FSM with a reloadable down-counter.
// Define PULSE_COUNT_EN to add the 16-bit PulseCount output.
module rate_enable_gen
  import rate_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int CNT_W    = 28
) (
  input  logic               Clock,
  input  logic               Clear,
  rate_enable_gen_if.slave   bus,
  output state_t             o_dbg_state
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   w_rem_next;
  logic [1:0]         r_speed_q;
  logic [1:0]         w_speed_q_next;
  logic               r_enable;
  logic               w_enable_next;
  logic               r_busy;
  logic               w_step_rise;
  logic [CNT_W-1:0]   w_load_in;
  logic [CNT_W-1:0]   w_load_q;

  step_edge_detect u_step_edge (
    .Clock  (Clock),
    .Clear  (Clear),
    .i_step (bus.Step),
    .o_rise (w_step_rise)
  );

  assign w_load_in = CNT_W'(reload_val(bus.Speed, 64'(CLK_FREQ)));
  assign w_load_q  = CNT_W'(reload_val(r_speed_q, 64'(CLK_FREQ)));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_speed_q <= SPD_FULL;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rem     <= w_rem_next;
      r_speed_q <= w_speed_q_next;
      r_enable  <= w_enable_next;
      r_busy    <= (w_next_state == ST_RUN);
    end
  end

  // Run outranks Step when both arrive in IDLE on the same edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.Run)          w_next_state = ST_RUN;
        else if (w_step_rise) w_next_state = ST_STEP;
      end
      ST_RUN:  if (!bus.Run)  w_next_state = ST_IDLE;
      ST_STEP:                w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // A speed change restarts the count and suppresses this cycle's pulse.
  always_comb begin
    w_rem_next     = r_rem;
    w_speed_q_next = r_speed_q;
    w_enable_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Run) begin
          w_rem_next     = w_load_in;
          w_speed_q_next = bus.Speed;
        end else if (w_step_rise) begin
          w_enable_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.Run) begin
          w_rem_next = '0;
        end else if (bus.Speed != r_speed_q) begin
          w_rem_next     = w_load_in;
          w_speed_q_next = bus.Speed;
        end else if (r_rem == '0) begin
          w_enable_next = 1'b1;
          w_rem_next    = w_load_q;
        end else begin
          w_rem_next = r_rem - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.Enable  = r_enable;
  assign bus.Busy    = r_busy;
  assign o_dbg_state = r_state;

`ifdef PULSE_COUNT_EN
  logic [15:0] r_pulse_cnt;

  always_ff @(posedge Clock) begin
    if (Clear)         r_pulse_cnt <= 16'd0;
    else if (r_enable) r_pulse_cnt <= r_pulse_cnt + 16'd1;
  end

  assign bus.PulseCount = r_pulse_cnt;
`endif

endmodule

// File: tb/tb_rate_enable_gen.sv
// Bench for rate_enable_gen at CLK_FREQ=4: event-time model checked every cycle plus literal pulse schedules.
// PulseCount checks are compiled only with PULSE_COUNT_EN.
module tb_rate_enable_gen;
  import rate_pkg::*;

  localparam int CF = 4;
  localparam int CW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  rate_enable_gen_if bus ();
  state_t dbg_state;

  rate_enable_gen #(.CLK_FREQ(CF), .CNT_W(CW)) dut (
    .Clock       (clk),
    .Clear       (clear),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // model: absolute cycle of the next pulse, rescheduled on entry or speed change
  function automatic longint reload_of(input int spd);
    if (spd == 0) return 0;
    return longint'((CF << (spd - 1)) - 1);
  endfunction

  int          m_mode = 0;  // 0 idle, 1 run, 2 step pulse
  int          m_spd = 0;
  longint      m_next = 0;
  bit          m_prev_step = 1'b0;
  bit          exp_en = 1'b0;
  bit          exp_busy = 1'b0;
  logic [15:0] exp_pcnt = 16'd0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    longint n;
    bit     new_en;
    n = longint'(cyc);
    if (clear) begin
      m_mode = 0; m_prev_step = 1'b0;
      exp_en = 1'b0; exp_busy = 1'b0; exp_pcnt = 16'd0;
    end else begin
      if (exp_en) exp_pcnt = exp_pcnt + 16'd1;
      new_en = 1'b0;
      case (m_mode)
        0: begin
          if (bus.Run) begin
            m_mode = 1; m_spd = int'(bus.Speed);
            m_next = n + 2 + reload_of(m_spd);
          end else if (bus.Step && !m_prev_step) begin
            m_mode = 2; new_en = 1'b1;
          end
        end
        1: begin
          if (!bus.Run) m_mode = 0;
          else if (int'(bus.Speed) != m_spd) begin
            m_spd = int'(bus.Speed);
            m_next = n + 2 + reload_of(m_spd);
          end else if (n + 1 == m_next) begin
            new_en = 1'b1;
            m_next = m_next + reload_of(m_spd) + 1;
          end
        end
        default: m_mode = 0;
      endcase
      exp_en = new_en;
      exp_busy = (m_mode == 1);
      m_prev_step = bus.Step;
    end
    m_valid = 1'b1;
    cyc = cyc + 1;
  end

  // scoreboard: pulse cycles relative to t0 inside window 1..win
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int t0 = 0;
  int win = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("enable", 32'(bus.Enable), 32'(exp_en));
      chk("busy", 32'(bus.Busy), 32'(exp_busy));
`ifdef PULSE_COUNT_EN
      chk("pulse_count", 32'(bus.PulseCount), 32'(exp_pcnt));
`endif
      if (bus.Enable && (cyc - t0) >= 1 && (cyc - t0) <= win)
        obs_q.push_back(16'(cyc - t0));
    end
  end

  task automatic compare_q(input string nm);
    string s_obs, s_exp;
    bit ok;
    ok = (obs_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      s_obs = ""; s_exp = "";
      foreach (obs_q[i]) if (i < 12) s_obs = {s_obs, $sformatf(" %0d", obs_q[i])};
      foreach (exp_q[i]) if (i < 12) s_exp = {s_exp, $sformatf(" %0d", exp_q[i])};
      $display("FAIL %s pulses got [%s ] expected [%s ]", nm, s_obs, s_exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start_window(input int w);
    obs_q.delete(); exp_q.delete();
    t0 = cyc; win = w;
  endtask

  task automatic run_test(input string nm, input logic [1:0] spd, input int w);
    start_window(w);
    bus.Speed = spd; bus.Run = 1'b1;
    tick(w);
    bus.Run = 1'b0;
    tick(2);
    compare_q(nm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Speed = SPD_FULL; bus.Run = 1'b0; bus.Step = 1'b0;
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    chk("reset_enable", 32'(bus.Enable), 32'd0);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    tick(2);

    // full rate: pulse every cycle from cycle 2, Busy from cycle 1
    start_window(6);
    bus.Speed = SPD_FULL; bus.Run = 1'b1;
    tick(1);
    chk("full_busy_c1", 32'(bus.Busy), 32'd1);
    chk("full_en_c1", 32'(bus.Enable), 32'd0);
    tick(5);
    bus.Run = 1'b0;
    tick(2);
    exp_q = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    compare_q("full_rate");
    tick(2);

    exp_q.delete();
    begin
      start_window(14);
      exp_q = '{16'd5, 16'd9, 16'd13};
      bus.Speed = SPD_1HZ; bus.Run = 1'b1;
      tick(14); bus.Run = 1'b0; tick(2);
      compare_q("rate_1hz");
    end
    tick(2);

    start_window(18);
    exp_q = '{16'd9, 16'd17};
    bus.Speed = SPD_HALF; bus.Run = 1'b1;
    tick(18); bus.Run = 1'b0; tick(2);
    compare_q("rate_half");
    tick(2);

    start_window(34);
    exp_q = '{16'd17, 16'd33};
    bus.Speed = SPD_QTR; bus.Run = 1'b1;
    tick(34); bus.Run = 1'b0; tick(2);
    compare_q("rate_qtr");
    tick(2);

    // speed 01 -> 11 at cycle 7: nothing until 7+17, then every 16
    start_window(41);
    exp_q = '{16'd5, 16'd24, 16'd40};
    bus.Speed = SPD_1HZ; bus.Run = 1'b1;
    tick(7);
    bus.Speed = SPD_QTR;
    tick(34);
    bus.Run = 1'b0; tick(2);
    compare_q("speed_change");
    tick(2);

    // held Step: one pulse in cycle s+1, Busy stays low
    start_window(6);
    exp_q = '{16'd1};
    bus.Speed = SPD_1HZ; bus.Step = 1'b1;
    tick(1);
    chk("step_state", 32'(dbg_state), 32'(ST_STEP));
    chk("step_busy", 32'(bus.Busy), 32'd0);
    tick(2);
    bus.Step = 1'b0;
    tick(4);
    compare_q("step_single");
    tick(2);

    // Step and Run on the same edge: RUN wins, no step pulse
    start_window(6);
    exp_q = '{16'd5};
    bus.Speed = SPD_1HZ; bus.Run = 1'b1; bus.Step = 1'b1;
    tick(1);
    chk("step_run_state", 32'(dbg_state), 32'(ST_RUN));
    tick(5);
    bus.Run = 1'b0; bus.Step = 1'b0; tick(2);
    compare_q("step_with_run");
    tick(2);

    // Clear at Remaining=2 with Run held: restart after release
    start_window(15);
    exp_q = '{16'd10, 16'd14};
    bus.Speed = SPD_1HZ; bus.Run = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    chk("clear_enable", 32'(bus.Enable), 32'd0);
    chk("clear_busy", 32'(bus.Busy), 32'd0);
    tick(2);
    clear = 1'b0;
    tick(10);
    bus.Run = 1'b0; tick(2);
    compare_q("clear_mid_count");
    tick(2);

`ifdef PULSE_COUNT_EN
    clear = 1'b1; tick(1); clear = 1'b0;
    start_window(0);
    bus.Speed = SPD_FULL; bus.Run = 1'b1;
    tick(65537);
    chk("pcnt_ffff", 32'(bus.PulseCount), 32'h0000_ffff);
    tick(1);
    chk("pcnt_wrap", 32'(bus.PulseCount), 32'h0000_0000);
    bus.Run = 1'b0; tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
